stack_engine: RTL and testbench

Parametrised gameplay engine for the block-stacking game. It merges the control FSM and datapath into one block. A moving block sweeps horizontally at the current row, and a drop press evaluates its overlap with the block below. On overlap the block is trimmed to the overlapping span and stacked; on a miss one chance is consumed. It adds bounce movement, per-level speed-up, width trimming, win detection and a draw handshake with the display FSM.

---
 rtl/stack_engine.sv | 120 ++++++++++++
 tb/tb_stack_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// stack_engine: block-stacking game engine with bounce movement, overlap trimming,
// lives, win detection and a draw_req/draw_ack handshake to the display.
module stack_engine #(
    parameter int SCREEN_W    = 160,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int BLOCK_W0    = 32,
    parameter int BLOCK_H     = 8,
    parameter int BASE_Y      = 120,
    parameter int MAX_LEVEL   = 14,
    parameter int LIVES       = 3,
    parameter int SPEED_SHIFT = 2,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               drop,
    input  logic               draw_ack,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [X_W-1:0]     width,
    output logic [X_W-1:0]     prev_x,
    output logic [X_W-1:0]     prev_width,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         chances,
    output logic               overlap,
    output logic [1:0]         game_status,
    output logic               draw_req
);
    typedef enum logic [2:0] {IDLE, SPAWN, MOVE, EVAL, PLACE, MISS, OVER, WIN} state_t;

    localparam logic [X_W-1:0] X_HOME = X_W'((SCREEN_W - BLOCK_W0) / 2);
    localparam logic [X_W-1:0] W_INIT = X_W'(BLOCK_W0);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(BASE_Y - BLOCK_H);

    state_t         state;
    logic           dir_left, drop_pend, at_right, at_left, hit;
    logic [X_W-1:0] step_raw, step, x_max, x_next, lo;
    logic [X_W:0]   r_cur, r_prev, hi;
    logic [Y_W-1:0] spawn_y;

    always_comb begin
        step_raw = X_W'(score >> SPEED_SHIFT) + X_W'(1);
        step     = step_raw > width ? width : step_raw;
        x_max    = X_W'(SCREEN_W) - width;
        at_right = ({1'b0, x} + {1'b0, step}) >= {1'b0, x_max};
        at_left  = x <= step;
        x_next   = dir_left ? (at_left ? '0 : x - step) : (at_right ? x_max : x + step);
        lo       = x > prev_x ? x : prev_x;
        r_cur    = {1'b0, x} + {1'b0, width};
        r_prev   = {1'b0, prev_x} + {1'b0, prev_width};
        hi       = r_cur < r_prev ? r_cur : r_prev;
        hit      = hi > {1'b0, lo};
        spawn_y  = Y_W'(BASE_Y - BLOCK_H * (int'(score) + 1));
    end

    always_ff @(posedge clk) begin
        if (reset || (start && (state == IDLE || state == OVER || state == WIN))) begin
            state       <= reset ? IDLE : SPAWN;
            x           <= '0;
            y           <= Y_INIT;
            width       <= W_INIT;
            prev_x      <= X_HOME;
            prev_width  <= W_INIT;
            score       <= '0;
            chances     <= 4'(LIVES);
            overlap     <= 1'b0;
            game_status <= 2'b00;
            draw_req    <= 1'b0;
            dir_left    <= 1'b0;
            drop_pend   <= 1'b0;
        end else begin
            // a new frame request in the same cycle outranks the ack clearing it
            if (draw_req && draw_ack) draw_req <= 1'b0;
            case (state)
                SPAWN: if (!draw_req || draw_ack) begin
                    x           <= '0;
                    dir_left    <= 1'b0;
                    y           <= spawn_y;
                    draw_req    <= 1'b1;
                    game_status <= 2'b01;
                    state       <= MOVE;
                end
                MOVE: begin
                    if (draw_req) drop_pend <= drop_pend | drop;
                    else if (drop || drop_pend) begin
                        drop_pend <= 1'b0;
                        state     <= EVAL;
                    end else if (tick) begin
                        x        <= x_next;
                        dir_left <= dir_left ? !at_left : at_right;
                        draw_req <= 1'b1;
                    end
                end
                EVAL: state <= hit ? PLACE : MISS;
                PLACE: begin
                    overlap     <= 1'b1;
                    prev_x      <= lo;
                    prev_width  <= X_W'(hi - {1'b0, lo});
                    width       <= X_W'(hi - {1'b0, lo});
                    x           <= lo;
                    score       <= score + SCORE_W'(1);
                    draw_req    <= 1'b1;
                    state       <= score == SCORE_W'(MAX_LEVEL - 1) ? WIN : SPAWN;
                    game_status <= score == SCORE_W'(MAX_LEVEL - 1) ? 2'b11 : game_status;
                end
                MISS: begin
                    overlap     <= 1'b0;
                    chances     <= chances - 4'd1;
                    draw_req    <= 1'b1;
                    state       <= chances == 4'd1 ? OVER : SPAWN;
                    game_status <= chances == 4'd1 ? 2'b10 : game_status;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: randomized and directed checks of stack_engine against a
// transaction-level game model.
module tb_stack_engine;
    logic clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, drop = 1'b0, draw_ack = 1'b0;
    logic [7:0] x, width, prev_x, prev_width;
    logic [6:0] y;
    logic [3:0] score, chances;
    logic       overlap, draw_req;
    logic [1:0] game_status;
    int checks = 0, failures = 0;
    int m_x, m_dir, m_w, m_px, m_pw, m_score, m_ch, m_st, m_ov, m_y;

    always #5 clk = ~clk;

    stack_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .drop(drop), .draw_ack(draw_ack),
        .x(x), .y(y), .width(width), .prev_x(prev_x), .prev_width(prev_width), .score(score),
        .chances(chances), .overlap(overlap), .game_status(game_status), .draw_req(draw_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_x = 0; m_dir = 0; m_w = 32; m_px = 64; m_pw = 32;
        m_score = 0; m_ch = 3; m_st = 0; m_ov = 0; m_y = 112;
    endtask

    task automatic m_spawn();
        m_x = 0; m_dir = 0; m_y = 120 - (m_score + 1) * 8; m_st = 1;
    endtask

    task automatic m_tick();
        int step;
        step = 1 + (m_score >> 2);
        if (step > m_w) step = m_w;
        if (m_dir == 0) begin
            if (m_x + step >= 160 - m_w) begin m_x = 160 - m_w; m_dir = 1; end
            else m_x += step;
        end else begin
            if (m_x <= step) begin m_x = 0; m_dir = 0; end
            else m_x -= step;
        end
    endtask

    task automatic m_drop();
        int l, r;
        l = m_x > m_px ? m_x : m_px;
        r = (m_x + m_w) < (m_px + m_pw) ? m_x + m_w : m_px + m_pw;
        if (r > l) begin
            m_ov = 1; m_px = l; m_pw = r - l; m_w = r - l; m_x = l; m_score++;
            if (m_score == 14) m_st = 3;
        end else begin
            m_ov = 0; m_ch--;
            if (m_ch == 0) m_st = 2;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_x"}, x, m_x);
        check({tag, "_y"}, y, m_y);
        check({tag, "_width"}, width, m_w);
        check({tag, "_prev_x"}, prev_x, m_px);
        check({tag, "_prev_width"}, prev_width, m_pw);
        check({tag, "_score"}, score, m_score);
        check({tag, "_chances"}, chances, m_ch);
        check({tag, "_overlap"}, overlap, m_ov);
        check({tag, "_status"}, game_status, m_st);
    endtask

    // acknowledge frames at random moments until the engine stays quiet
    task automatic settle();
        int z = 0;
        for (int i = 0; i < 300 && z < 3; i++) begin
            draw_ack = draw_req && ($urandom_range(0, 1) == 1);
            cyc();
            z = draw_req ? 0 : z + 1;
        end
        draw_ack = 1'b0;
        check("settle_dreq", draw_req, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_reset();
        check_all("reset");
        check("reset_dreq", draw_req, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (m_st != 1) begin m_reset(); m_spawn(); end
        settle();
        check_all("start");
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if (m_st == 1) m_tick();
        check("tick_x", x, m_x);
        check("tick_dreq", draw_req, m_st == 1);
        settle();
    endtask

    task automatic do_drop();
        int playing;
        playing = m_st == 1;
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        cyc();
        check("drop_early_score", score, m_score);
        check("drop_early_chances", chances, m_ch);
        cyc();
        if (playing) m_drop();
        check_all("drop");
        check("drop_dreq", draw_req, playing);
        settle();
        if (m_st == 1) m_spawn();
        check_all("spawn");
    endtask

    task automatic tick_to(input int target);
        for (int i = 0; i < 400 && m_x != target; i++) do_tick();
        check("tick_to", x, target);
    endtask

    task automatic aim();
        for (int i = 0; i < 400 && !(m_x >= m_px && m_dir == 0); i++) do_tick();
    endtask

    initial begin
        m_reset();
        cyc();
        cyc();
        do_reset();
        check("reset_x_const", x, 0);
        check("reset_prev_x_const", prev_x, 64);
        check("reset_y_const", y, 112);

        // perfect drop at x=64
        do_start();
        check("start_status", game_status, 1);
        tick_to(64);
        do_drop();
        check("perfect_overlap", overlap, 1);
        check("perfect_score", score, 1);
        check("perfect_width", width, 32);
        check("perfect_prev_x", prev_x, 64);
        check("perfect_next_y", y, 104);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("start_ignored_score", score, 1);
        check("start_ignored_status", game_status, 1);

        // partial trim
        do_reset();
        do_start();
        tick_to(80);
        do_drop();
        check("trim_width", width, 16);
        check("trim_prev_x", prev_x, 80);
        check("trim_prev_width", prev_width, 16);
        check("trim_spawn_x", x, 0);

        // three misses end the game
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) begin
            do_drop();
            check("miss_chances", chances, 2 - i);
        end
        check("over_status", game_status, 2);
        for (int i = 0; i < 3; i++) do_tick();
        check("over_x_frozen", x, 0);
        do_drop();
        check("over_drop_ignored", chances, 0);

        // bounce at the right edge, then speed at score 4
        do_reset();
        do_start();
        tick_to(128);
        do_tick();
        check("bounce_left", x, 127);
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin aim(); do_drop(); end
        check("speed_score", score, 4);
        do_tick();
        check("speed_step1", x, 2);
        do_tick();
        check("speed_step2", x, 4);

        // handshake stall with a drop latched during the stall
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        m_tick();
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            check("stall_x", x, m_x);
            check("stall_dreq", draw_req, 1);
        end
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        cyc();
        check("stall_drop_wait", score, m_score);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
        check("stall_ack_dreq", draw_req, 0);
        cyc();
        cyc();
        check("stall_drop_pending", score, m_score);
        cyc();
        m_drop();
        check_all("stall_drop");
        settle();
        if (m_st == 1) m_spawn();
        check_all("stall_spawn");

        // reset mid-game, then play to a win
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin aim(); do_drop(); end
        check("mid_score", score, 5);
        do_reset();
        do_start();
        for (int i = 0; i < 20 && m_st == 1; i++) begin aim(); do_drop(); end
        check("win_status", game_status, 3);
        check("win_score", score, 14);

        // random play
        for (int i = 0; i < 150; i++) begin
            int r;
            if (m_st != 1) do_start();
            r = $urandom_range(0, 9);
            if (r < 7) do_tick();
            else do_drop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
